// File: rtl/param_stack_if.sv
// Push/pop handshake and status bundle for param_stack.
// The master drives the strobes and data. The slave is the stack and drives the read port and flags.
interface param_stack_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, din,
    input  dout, dout_valid, count, empty, full, almost_full, overflow, underflow
  );

  modport slave (
    input  push, pop, din,
    output dout, dout_valid, count, empty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO stack with a registered read port, status flags and error pulses.
// A simultaneous push and pop replaces the top entry, or passes din straight through when the stack is empty.
module param_stack #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AW        = 5,
  parameter int AFULL_LVL = 30
) (
  input  logic         i_clk,
  input  logic         i_rst,
  param_stack_if.slave s_if
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AFULL = (AW+1)'(AFULL_LVL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_sp;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic          w_empty;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_replace;
  logic          w_bypass;
  logic          w_wr_en;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_wr_idx;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == LP_DEPTH);
  assign w_do_push = s_if.push & ~s_if.pop & ~w_full;
  assign w_do_pop  = s_if.pop & ~s_if.push & ~w_empty;
  assign w_replace = s_if.push & s_if.pop & ~w_empty;
  assign w_bypass  = s_if.push & s_if.pop & w_empty;
  assign w_wr_en   = ~i_rst & (w_do_push | w_replace);

  // At sp == 2**AW the low bits are zero, so the subtraction wraps to the correct top slot.
  assign w_top_idx = r_sp[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
  assign w_wr_idx  = w_replace ? w_top_idx : r_sp[AW-1:0];

  // The storage array has no reset: its contents are invisible while sp is 0.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= s_if.din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sp         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= w_do_pop | w_replace | w_bypass;
      r_overflow   <= s_if.push & ~s_if.pop & w_full;
      r_underflow  <= s_if.pop & ~s_if.push & w_empty;
      if (w_do_push) begin
        r_sp <= r_sp + 1'b1;
      end else if (w_do_pop) begin
        r_sp <= r_sp - 1'b1;
      end
      if (w_do_pop | w_replace) begin
        r_dout <= r_mem[w_top_idx];
      end else if (w_bypass) begin
        r_dout <= s_if.din;
      end
    end
  end

  assign s_if.dout        = r_dout;
  assign s_if.dout_valid  = r_dout_valid;
  assign s_if.count       = r_sp;
  assign s_if.empty       = w_empty;
  assign s_if.full        = w_full;
  assign s_if.almost_full = (r_sp >= LP_AFULL);
  assign s_if.overflow    = r_overflow;
  assign s_if.underflow   = r_underflow;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: directed scenarios followed by random traffic.
// Every output is compared each cycle against a queue-based reference model.
module tb_param_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int AFULL = 30;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [WIDTH-1:0] stk[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid;
  logic             m_ovf;
  logic             m_udf;

  param_stack_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  param_stack #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .AFULL_LVL(AFULL)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .s_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour per edge, using the stack depth as it was before the edge.
  task automatic model_edge(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic r);
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    if (r) begin
      stk.delete();
      m_dout = '0;
    end else if (p && !q) begin
      if (stk.size() == DEPTH) m_ovf = 1'b1;
      else stk.push_back(d);
    end else if (!p && q) begin
      if (stk.size() == 0) m_udf = 1'b1;
      else begin
        m_dout  = stk.pop_back();
        m_valid = 1'b1;
      end
    end else if (p && q) begin
      m_valid = 1'b1;
      if (stk.size() == 0) m_dout = d;
      else begin
        m_dout = stk[stk.size()-1];
        stk[stk.size()-1] = d;
      end
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = stk.size();
    check("dout",        32'(bus.dout),        32'(m_dout));
    check("dout_valid",  32'(bus.dout_valid),  32'(m_valid));
    check("count",       32'(bus.count),       32'(sz));
    check("empty",       32'(bus.empty),       32'(sz == 0));
    check("full",        32'(bus.full),        32'(sz == DEPTH));
    check("almost_full", 32'(bus.almost_full), 32'(sz >= AFULL));
    check("overflow",    32'(bus.overflow),    32'(m_ovf));
    check("underflow",   32'(bus.underflow),   32'(m_udf));
  endtask

  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    bus.push = p;
    bus.pop  = q;
    bus.din  = d;
    @(posedge clk);
    model_edge(p, q, d, rst);
    #1;
    compare_all();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = '0;
    rst = 1'b1;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    rst = 1'b0;
    step(0, 0, 8'h00);
    check("reset_dout", 32'(bus.dout), 32'h0);
    check("reset_empty", 32'(bus.empty), 32'h1);

    // Three pushes, then three pops come back in reverse order.
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    step(0, 1, 8'h00);
    check("lifo_pop1", 32'(bus.dout), 32'h33);
    step(0, 1, 8'h00);
    check("lifo_pop2", 32'(bus.dout), 32'h22);
    step(0, 1, 8'h00);
    check("lifo_pop3", 32'(bus.dout), 32'h11);
    check("lifo_empty", 32'(bus.empty), 32'h1);

    // Fill to DEPTH, overflow, then pop the last word pushed.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 8'(i));
      if (i == AFULL - 2) check("afull_below", 32'(bus.almost_full), 32'h0);
      if (i == AFULL - 1) check("afull_at",    32'(bus.almost_full), 32'h1);
    end
    check("full_at_depth", 32'(bus.full), 32'h1);
    step(1, 0, 8'hAA);
    check("ovf_pulse", 32'(bus.overflow), 32'h1);
    check("ovf_count", 32'(bus.count), 32'(DEPTH));
    step(0, 1, 8'h00);
    check("pop_after_ovf", 32'(bus.dout), 32'h1F);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 8'h00);
    check("drained_last", 32'(bus.dout), 32'h00);

    // Pop on empty, then bypass on empty.
    step(0, 1, 8'h00);
    check("udf_pulse", 32'(bus.underflow), 32'h1);
    check("udf_dout_hold", 32'(bus.dout), 32'h00);
    step(1, 1, 8'h5C);
    check("bypass_dout", 32'(bus.dout), 32'h5C);
    check("bypass_count", 32'(bus.count), 32'h0);

    // Replace-top.
    step(1, 0, 8'h01);
    step(1, 0, 8'h02);
    step(1, 1, 8'h77);
    check("replace_old", 32'(bus.dout), 32'h02);
    check("replace_count", 32'(bus.count), 32'h2);
    step(0, 1, 8'h00);
    check("replace_new", 32'(bus.dout), 32'h77);
    step(0, 1, 8'h00);
    check("replace_bottom", 32'(bus.dout), 32'h01);

    // Reset takes priority over a pop in flight.
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i));
    rst = 1'b1;
    step(0, 1, 8'h00);
    rst = 1'b0;
    check("rst_pop_count", 32'(bus.count), 32'h0);
    check("rst_pop_valid", 32'(bus.dout_valid), 32'h0);
    step(0, 1, 8'h00);
    check("rst_then_udf", 32'(bus.underflow), 32'h1);

    // Random traffic with phases biased toward filling or draining the stack.
    for (int ph = 0; ph < 12; ph++) begin
      int push_pct;
      int pop_pct;
      push_pct = (ph % 2 == 0) ? 85 : 20;
      pop_pct  = (ph % 2 == 0) ? 25 : 80;
      for (int c = 0; c < 150; c++) begin
        logic p;
        logic q;
        p   = ($urandom_range(99) < push_pct);
        q   = ($urandom_range(99) < pop_pct);
        rst = ($urandom_range(299) == 0);
        step(p, q, 8'($urandom));
      end
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
